// File: rtl/close_to_b_pkg.sv
// Shared types and constants for the A-close-to-B requester.
// The optional PERF_CNT_EN build also uses the saturating increment helper below.
package close_to_b_pkg;

  localparam int CTB_W_DEF   = 12;
  localparam int CTB_TMO_DEF = 1024;

  // One-hot sequencer states; the encoding is visible on Dbg_State.
  typedef enum logic [4:0] {
    ST_IDLE = 5'b00001,
    ST_REQ  = 5'b00010,
    ST_WAIT = 5'b00100,
    ST_ACKW = 5'b01000,
    ST_OUT  = 5'b10000
  } state_t;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ORDER = 2'b01;
  localparam logic [1:0] ERR_TMO   = 2'b10;

  function automatic int ctb_cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/close_to_b_watchdog.sv
// WAIT-phase cycle counter with synchronous clear and terminal-count flag.
// The flag rises once the count reaches TMO_CYC-1; the count never runs past it.
module close_to_b_watchdog
  import close_to_b_pkg::*;
#(
  parameter int TMO_CYC = CTB_TMO_DEF,
  parameter int CW      = ctb_cnt_width(TMO_CYC)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_inc,
  input  logic          i_clr,
  output logic [CW-1:0] o_cnt,
  output logic          o_tc
);

  logic [CW-1:0] r_cnt;
  logic          w_tc;

  assign w_tc = (r_cnt == CW'(TMO_CYC - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !w_tc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = w_tc;

endmodule

// File: rtl/close_to_b_requester.sv
// Initiator-side sequencer for the A-close-to-B adjust engine: accepts (A,B), drives
// Start/Ack, captures the result and hands it downstream. Optional macro: PERF_CNT_EN.
module close_to_b_requester
  import close_to_b_pkg::*;
#(
  parameter int W       = CTB_W_DEF,
  parameter int TMO_CYC = CTB_TMO_DEF
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         In_Valid,
  output logic         In_Ready,
  input  logic [W-1:0] In_A,
  input  logic [W-1:0] In_B,
  output logic         Eng_Start,
  output logic         Eng_Ack,
  output logic [W-1:0] Eng_Ain,
  output logic [W-1:0] Eng_Bin,
  input  logic         Eng_Qi,
  input  logic         Eng_Qc,
  input  logic         Eng_Qd,
  input  logic [W-1:0] Eng_A,
  output logic         Out_Valid,
  input  logic         Out_Ready,
  output logic [W-1:0] Out_A,
  output logic [W-1:0] Out_B,
  output logic [1:0]   Out_Err,
  output logic         Eng_Fault,
  output logic         Busy,
`ifdef PERF_CNT_EN
  output logic [15:0]  Cnt_Ok,
  output logic [15:0]  Cnt_Err,
  output logic [15:0]  Max_Lat,
`endif
  output logic [4:0]   Dbg_State
);

  localparam int CW = ctb_cnt_width(TMO_CYC);

  // Handshakes: a transfer happens on a rising edge where valid && ready; the source
  // holds its payload steady while valid is high and ready is low.
  state_t        r_state;
  logic          r_start;
  logic          r_ack;
  logic          r_fault;
  logic          r_out_valid;
  logic [W-1:0]  r_ain;
  logic [W-1:0]  r_bin;
  logic [W-1:0]  r_out_a;
  logic [W-1:0]  r_out_b;
  logic [1:0]    r_out_err;

  logic          w_in_ready;
  logic          w_accept;
  logic          w_handoff;
  logic          w_wd_inc;
  logic          w_wd_clr;
  logic          w_wd_tc;
  logic [CW-1:0] w_wd_cnt;
  logic          w_unused_sink;

  assign w_in_ready = (r_state == ST_IDLE) && !r_fault;
  assign w_accept   = w_in_ready && In_Valid;
  assign w_handoff  = (r_state == ST_OUT) && Out_Ready;
  assign w_wd_inc   = (r_state == ST_WAIT);
  assign w_wd_clr   = w_handoff;

  close_to_b_watchdog #(
    .TMO_CYC (TMO_CYC),
    .CW      (CW)
  ) u_watchdog (
    .i_clk   (Clk),
    .i_rst_n (Reset),
    .i_inc   (w_wd_inc),
    .i_clr   (w_wd_clr),
    .o_cnt   (w_wd_cnt),
    .o_tc    (w_wd_tc)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state     <= ST_IDLE;
      r_start     <= 1'b0;
      r_ack       <= 1'b0;
      r_fault     <= 1'b0;
      r_out_valid <= 1'b0;
      r_ain       <= '0;
      r_bin       <= '0;
      r_out_a     <= '0;
      r_out_b     <= '0;
      r_out_err   <= ERR_OK;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_ain   <= In_A;
            r_bin   <= In_B;
            r_out_b <= In_B;
            if (In_A < In_B) begin
              r_start <= 1'b1;
              r_state <= ST_REQ;
            end else begin
              // A>=B: the engine would never converge, so skip it entirely.
              r_out_a     <= In_A;
              r_out_err   <= ERR_ORDER;
              r_out_valid <= 1'b1;
              r_state     <= ST_OUT;
            end
          end
        end
        ST_REQ: begin
          if (!Eng_Qi) begin
            r_start <= 1'b0;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (Eng_Qd) begin
            r_out_a   <= Eng_A;
            r_out_err <= ERR_OK;
            r_ack     <= 1'b1;
            r_state   <= ST_ACKW;
          end else if (w_wd_tc) begin
            // No Ack on timeout: the engine is presumed stuck until reset.
            r_out_a     <= Eng_A;
            r_out_err   <= ERR_TMO;
            r_fault     <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= ST_OUT;
          end
        end
        ST_ACKW: begin
          if (Eng_Qi) begin
            r_ack       <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (Out_Ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_start     <= 1'b0;
          r_ack       <= 1'b0;
          r_out_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign In_Ready  = w_in_ready;
  assign Eng_Start = r_start && !r_fault;
  assign Eng_Ack   = r_ack && !r_fault;
  assign Eng_Ain   = r_ain;
  assign Eng_Bin   = r_bin;
  assign Out_Valid = r_out_valid;
  assign Out_A     = r_out_a;
  assign Out_B     = r_out_b;
  assign Out_Err   = r_out_err;
  assign Eng_Fault = r_fault;
  assign Busy      = (r_state != ST_IDLE);
  assign Dbg_State = r_state;

`ifdef PERF_CNT_EN
  logic [15:0] r_cnt_ok;
  logic [15:0] r_cnt_err;
  logic [15:0] r_max_lat;
  logic [15:0] w_wd_lat;

  assign w_wd_lat = 16'(w_wd_cnt);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_cnt_ok  <= '0;
      r_cnt_err <= '0;
      r_max_lat <= '0;
    end else begin
      if (w_handoff) begin
        if (r_out_err == ERR_OK) begin
          r_cnt_ok <= sat_inc16(r_cnt_ok);
        end else begin
          r_cnt_err <= sat_inc16(r_cnt_err);
        end
      end
      if ((r_state == ST_WAIT) && Eng_Qd && (w_wd_lat > r_max_lat)) begin
        r_max_lat <= w_wd_lat;
      end
    end
  end

  assign Cnt_Ok        = r_cnt_ok;
  assign Cnt_Err       = r_cnt_err;
  assign Max_Lat       = r_max_lat;
  assign w_unused_sink = Eng_Qc;
`else
  // Qc carries no decision here; only Qd ends the WAIT phase.
  assign w_unused_sink = Eng_Qc ^ (^w_wd_cnt);
`endif

endmodule

// File: tb/tb_close_to_b_requester.sv
// Directed bench for close_to_b_requester with a behavioural engine stub attached.
// Engine stub: result = A + 5*((B-A-1)/5), delivered after eng_lat cycles in ADJ.
module tb_close_to_b_requester;

  localparam int W = 12;
  localparam int TMO = 16;
  localparam logic [4:0] S_IDLE = 5'b00001;
  localparam logic [4:0] S_WAIT = 5'b00100;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         eng_start;
  logic         eng_ack;
  logic [W-1:0] eng_ain;
  logic [W-1:0] eng_bin;
  logic         eng_qi;
  logic         eng_qc;
  logic         eng_qd;
  logic [W-1:0] eng_a;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_a;
  logic [W-1:0] out_b;
  logic [1:0]   out_err;
  logic         eng_fault;
  logic         busy;
  logic [4:0]   dbg_state;
`ifdef PERF_CNT_EN
  logic [15:0]  cnt_ok;
  logic [15:0]  cnt_err;
  logic [15:0]  max_lat;
`endif

  int total;
  int bad;

  close_to_b_requester #(.W(W), .TMO_CYC(TMO)) dut (
    .Clk       (clk),
    .Reset     (rst_n),
    .In_Valid  (in_valid),
    .In_Ready  (in_ready),
    .In_A      (in_a),
    .In_B      (in_b),
    .Eng_Start (eng_start),
    .Eng_Ack   (eng_ack),
    .Eng_Ain   (eng_ain),
    .Eng_Bin   (eng_bin),
    .Eng_Qi    (eng_qi),
    .Eng_Qc    (eng_qc),
    .Eng_Qd    (eng_qd),
    .Eng_A     (eng_a),
    .Out_Valid (out_valid),
    .Out_Ready (out_ready),
    .Out_A     (out_a),
    .Out_B     (out_b),
    .Out_Err   (out_err),
    .Eng_Fault (eng_fault),
    .Busy      (busy),
`ifdef PERF_CNT_EN
    .Cnt_Ok    (cnt_ok),
    .Cnt_Err   (cnt_err),
    .Max_Lat   (max_lat),
`endif
    .Dbg_State (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "global timeout");
  end

  // ---------------- engine stub ----------------
  typedef enum logic [1:0] {E_INI, E_ADJ, E_DONE} eng_st_t;
  eng_st_t      e_st;
  logic [W-1:0] e_a;
  logic [W-1:0] e_b;
  int           e_cnt;
  int           eng_lat;
  logic         eng_hang;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_st  <= E_INI;
      e_a   <= '0;
      e_b   <= '0;
      e_cnt <= 0;
    end else begin
      case (e_st)
        E_INI: if (eng_start) begin
          e_a   <= eng_ain;
          e_b   <= eng_bin;
          e_cnt <= eng_lat;
          e_st  <= E_ADJ;
        end
        E_ADJ: if (!eng_hang) begin
          if (e_cnt <= 1) begin
            e_a  <= W'(int'(e_a) + 5 * ((int'(e_b) - int'(e_a) - 1) / 5));
            e_st <= E_DONE;
          end else begin
            e_cnt <= e_cnt - 1;
          end
        end
        E_DONE: if (eng_ack) e_st <= E_INI;
        default: e_st <= E_INI;
      endcase
    end
  end

  assign eng_qi = (e_st == E_INI);
  assign eng_qc = (e_st == E_ADJ);
  assign eng_qd = (e_st == E_DONE);
  assign eng_a  = e_a;

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           lat;
    logic [W-1:0] exp_a;
    logic [1:0]   exp_err;
    int           hold;
  } vec_t;

  vec_t vecs[9];

  // ---------------- driver ----------------
  task automatic run_pair(input vec_t v);
    int n_start;
    int n_ack;
    int cyc;
    int exp_hs;
    n_start = 0;
    n_ack   = 0;
    cyc     = 0;
    eng_lat = v.lat;
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_a     = v.a;
    in_b     = v.b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("eng_ain", eng_ain, v.a);
    check("eng_bin", eng_bin, v.b);
    while (!out_valid && cyc < 100) begin
      if (eng_start) n_start++;
      if (eng_ack) n_ack++;
      @(negedge clk);
      cyc++;
    end
    check("out_valid_seen", out_valid, 1);
    exp_hs = (v.exp_err == 2'b00) ? 2 : 0;
    check("start_cycles", n_start, exp_hs);
    check("ack_cycles", n_ack, exp_hs);
    for (int i = 0; i < v.hold; i++) begin
      in_valid = 1'b1;
      in_a     = 12'hABC;
      in_b     = 12'h123;
      check("hold_out_a", out_a, v.exp_a);
      check("hold_out_err", out_err, v.exp_err);
      check("hold_in_ready", in_ready, 0);
      check("hold_eng_ain", eng_ain, v.a);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("out_a", out_a, v.exp_a);
    check("out_b", out_b, v.b);
    check("out_err", out_err, v.exp_err);
    check("busy_out", busy, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_drop", out_valid, 0);
    check("busy_idle", busy, 0);
    check("in_ready_after", in_ready, 1);
  endtask

  // ---------------- test ----------------
  initial begin
    int   exp_ok;
    int   exp_bad;
    int   exp_max;
    int   cyc;
    int   n_wait;
    vec_t v;

    total = 0;
    bad = 0;
    rst_n = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b0;
    eng_lat = 1;
    eng_hang = 1'b0;

    vecs[0] = '{a: 12'd100,  b: 12'd755,  lat: 3, exp_a: 12'd750,  exp_err: 2'b00, hold: 0};
    vecs[1] = '{a: 12'd800,  b: 12'd300,  lat: 1, exp_a: 12'd800,  exp_err: 2'b01, hold: 0};
    vecs[2] = '{a: 12'd500,  b: 12'd500,  lat: 1, exp_a: 12'd500,  exp_err: 2'b01, hold: 0};
    vecs[3] = '{a: 12'd0,    b: 12'd4095, lat: 2, exp_a: 12'd4090, exp_err: 2'b00, hold: 0};
    vecs[4] = '{a: 12'd4094, b: 12'd4095, lat: 1, exp_a: 12'd4094, exp_err: 2'b00, hold: 0};
    vecs[5] = '{a: 12'd4095, b: 12'd0,    lat: 1, exp_a: 12'd4095, exp_err: 2'b01, hold: 2};
    vecs[6] = '{a: 12'd100,  b: 12'd755,  lat: 6, exp_a: 12'd750,  exp_err: 2'b00, hold: 5};
    vecs[7] = '{a: 12'd200,  b: 12'd203,  lat: 4, exp_a: 12'd200,  exp_err: 2'b00, hold: 0};
    vecs[8] = '{a: 12'd1,    b: 12'd12,   lat: 9, exp_a: 12'd11,   exp_err: 2'b00, hold: 1};

    // reset values
    #3 rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_eng_start", eng_start, 0);
    check("rst_eng_ack", eng_ack, 0);
    check("rst_eng_ain", eng_ain, 0);
    check("rst_out_a", out_a, 0);
    check("rst_out_err", out_err, 0);
    check("rst_fault", eng_fault, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, S_IDLE);
    check("rst_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // table vectors
    exp_ok = 0;
    exp_bad = 0;
    exp_max = 0;
    for (int i = 0; i < 9; i++) begin
      run_pair(vecs[i]);
      if (vecs[i].exp_err == 2'b00) begin
        exp_ok++;
        if (vecs[i].lat - 1 > exp_max) exp_max = vecs[i].lat - 1;
      end else begin
        exp_bad++;
      end
    end
`ifdef PERF_CNT_EN
    check("cnt_ok", cnt_ok, exp_ok);
    check("cnt_err", cnt_err, exp_bad);
    check("max_lat", max_lat, exp_max);
`endif

    // timeout: engine never reaches DONE
    eng_hang = 1'b1;
    eng_lat = 1;
    @(negedge clk);
    in_a = 12'd10;
    in_b = 12'd40;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_wait = 0;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      if (dbg_state == S_WAIT) n_wait++;
      @(negedge clk);
      cyc++;
    end
    check("tmo_valid", out_valid, 1);
    check("tmo_wait_cycles", n_wait, TMO);
    check("tmo_err", out_err, 2'b10);
    check("tmo_out_a", out_a, 12'd10);
    check("tmo_out_b", out_b, 12'd40);
    check("tmo_fault", eng_fault, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_a = 12'd1;
    in_b = 12'd100;
    repeat (5) begin
      @(negedge clk);
      check("fault_in_ready", in_ready, 0);
      check("fault_busy", busy, 0);
      check("fault_start", eng_start, 0);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    eng_hang = 1'b0;
    check("fault_cleared", eng_fault, 0);
    check("fault_in_ready_back", in_ready, 1);

    // reset while in WAIT
    eng_lat = 10;
    in_a = 12'd5;
    in_b = 12'd2000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (dbg_state != S_WAIT && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("reached_wait", dbg_state, S_WAIT);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_start", eng_start, 0);
    check("mid_rst_ack", eng_ack, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_state", dbg_state, S_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    v = '{a: 12'd5, b: 12'd2000, lat: 3, exp_a: 12'd1995, exp_err: 2'b00, hold: 0};
    run_pair(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
